led_pattern_sched: RTL and testbench

Scheduler that shares the 16-LED bar (5+5+6 segments) between up to four LED pattern generators. It runs each generator's step clock-enable from a prescaled tick and picks the bar owner round-robin among the requesting DIP switches. Ownership changes only at frame boundaries, unless the owner withdraws its request. It sits between the board DIP switches, the pattern generator FSMs, and the LED pins.

---
 rtl/led_pattern_sched.sv | 138 +++++++++++++
 tb/tb_led_pattern_sched.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sched.sv
// led_pattern_sched: shares a 16-LED bar among four pattern generators, round-robin at frame boundaries.
// Define LED_SCHED_GAP_EN to blank the bar for GAP_STEPS ticks between different owners.
module led_pattern_sched #(
    parameter int DIV       = 12_500_000,
    parameter int DIV_W     = 24,
    parameter int STEPS     = 8,
    parameter int GAP_STEPS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] pat_in,
    output logic [3:0]  step_en,
    output logic [3:0]  grant,
    output logic [15:0] led_out,
    output logic        frame_done,
    output logic        busy
);
    localparam int SW = $clog2(STEPS);
`ifdef LED_SCHED_GAP_EN
    localparam int GW = (GAP_STEPS > 1) ? $clog2(GAP_STEPS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    if (DIV < 2 || STEPS < 2 || GAP_STEPS < 1) begin : g_bad_cfg
        $error("led_pattern_sched: invalid DIV/STEPS/GAP_STEPS");
    end

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d, ptr_q, ptr_d, win;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    step_q, step_d;
    logic [3:0]       req_m_q, req_s_q;
    logic [15:0]      led_q;
    logic             tick, drop, any, last;
`ifdef LED_SCHED_GAP_EN
    logic [GW-1:0]    gap_q, gap_d;
`endif

    assign any  = |req_s_q;
    assign tick = cnt_q == DIV_W'(DIV - 1);
    assign drop = !req_s_q[owner_q];
    assign last = step_q == SW'(STEPS - 1);

    // Scan downwards so the nearest requester after ptr is assigned last and wins.
    always_comb begin
        win = ptr_q;
        for (int k = 4; k >= 1; k--)
            if (req_s_q[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_m_q <= '0;
            req_s_q <= '0;
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            step_q  <= '0;
            led_q   <= '0;
`ifdef LED_SCHED_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            req_m_q <= req;
            req_s_q <= req_m_q;
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            led_q   <= (state_q == RUN) ? pat_in[16*owner_q +: 16] : 16'h0000;
`ifdef LED_SCHED_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = '0;
        step_d     = '0;
        step_en    = '0;
        frame_done = 1'b0;
`ifdef LED_SCHED_GAP_EN
        gap_d      = '0;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = RUN;
                    owner_d = win;
                    ptr_d   = win;
                end
            end
            RUN: begin
                step_en    = (tick && !drop) ? 4'b0001 << owner_q : 4'b0000;
                frame_done = tick && !drop && last;
                // Handover leaves both counters at their cleared defaults.
                if (drop || (tick && last && win != owner_q)) begin
`ifdef LED_SCHED_GAP_EN
                    state_d = any ? GAP : IDLE;
`else
                    state_d = any ? RUN : IDLE;
                    owner_d = win;
                    ptr_d   = win;
`endif
                end else begin
                    cnt_d  = tick ? '0 : cnt_q + DIV_W'(1);
                    step_d = tick ? (last ? '0 : step_q + SW'(1)) : step_q;
                end
            end
`ifdef LED_SCHED_GAP_EN
            GAP: begin
                cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
                gap_d = tick ? gap_q + GW'(1) : gap_q;
                if (tick && gap_q == GW'(GAP_STEPS - 1)) begin
                    state_d = any ? RUN : IDLE;
                    owner_d = win;
                    ptr_d   = win;
                    gap_d   = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign grant   = (state_q == RUN) ? 4'b0001 << owner_q : 4'b0000;
    assign led_out = led_q;
    assign busy    = state_q != IDLE;

endmodule

// File: tb/tb_led_pattern_sched.sv
// tb_led_pattern_sched: directed + random stimulus for led_pattern_sched, checked each cycle
// against a tick/frame arithmetic model (honours LED_SCHED_GAP_EN like the design).
module tb_led_pattern_sched;
    localparam int DIV = 4, STEPS = 8, GAP_STEPS = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] pat_in = '0;
    logic [3:0]  step_en, grant;
    logic [15:0] led_out;
    logic        frame_done, busy;
    int          checks = 0, fails = 0;
    bit          found;

    int          m_mode, m_owner, m_ptr, m_t;  // mode: 0 idle, 1 run, 2 gap; m_t = cycles since mode entry
    logic [3:0]  m_s1, m_s;
    logic [15:0] m_led;

    led_pattern_sched #(.DIV(DIV), .DIV_W(8), .STEPS(STEPS), .GAP_STEPS(GAP_STEPS)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .pat_in(pat_in), .step_en(step_en),
        .grant(grant), .led_out(led_out), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input int p, input logic [3:0] s);
        for (int k = 1; k <= 4; k++) if (s[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_ptr = 3; m_t = 0;
        m_s1 = '0; m_s = '0; m_led = '0;
    endtask

    task automatic take(input int w);
        m_mode = 1; m_owner = w; m_ptr = w; m_t = 0;
    endtask

    task automatic handover(input int w);
        if (w < 0) m_mode = 0;
`ifdef LED_SCHED_GAP_EN
        else begin m_mode = 2; m_t = 0; end
`else
        else take(w);
`endif
    endtask

    task automatic model_step();
        int          w    = winner(m_ptr, m_s);
        bit          tick = (m_t % DIV) == DIV - 1;
        logic [15:0] nled = (m_mode == 1) ? pat_in[16*m_owner +: 16] : 16'h0000;
        case (m_mode)
            0: if (w >= 0) take(w);
            1: begin
                if (!m_s[m_owner]) handover(w);
                else if (tick && (m_t / DIV) % STEPS == STEPS - 1 && w != m_owner) handover(w);
                else m_t++;
            end
            default: begin
                if (tick && m_t / DIV == GAP_STEPS - 1) begin
                    if (w >= 0) take(w); else m_mode = 0;
                end else m_t++;
            end
        endcase
        m_led = nled;
        m_s   = m_s1;
        m_s1  = req;
    endtask

    task automatic compare(input string tag);
        bit         tick = m_mode != 0 && (m_t % DIV) == DIV - 1;
        bit         stp  = m_mode == 1 && tick && m_s[m_owner];
        logic [3:0] oh   = 4'(1 << m_owner);
        check({tag, ":grant"}, 16'(grant), (m_mode == 1) ? 16'(oh) : 16'h0);
        check({tag, ":step_en"}, 16'(step_en), stp ? 16'(oh) : 16'h0);
        check({tag, ":frame_done"}, 16'(frame_done), 16'(stp && (m_t / DIV) % STEPS == STEPS - 1));
        check({tag, ":busy"}, 16'(busy), 16'(m_mode != 0));
        check({tag, ":led_out"}, led_out, m_led);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        #1;
        compare(tag);
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) begin
            pat_in = {$urandom, $urandom};
            cycle(tag);
        end
    endtask

    initial begin
        model_reset();
        run(3, "reset");
        rst_n = 1'b1;
        run(3, "idle");
        req = 4'b0001;
        run(2, "lat");
        check("lat_grant_early", 16'(grant), 16'h0);
        run(1, "lat");
        check("lat_grant", 16'(grant), 16'h1);
        run(2, "first_step");
        check("first_step_early", 16'(step_en), 16'h0);
        run(1, "first_step");
        check("first_step", 16'(step_en), 16'h1);
        run(80, "solo0");
        req = 4'b0101;
        run(100, "rr_0101");
        req = 4'b0001;
        run(40, "back0");
        req = 4'b0000;
        run(20, "drop_idle");
        req = 4'b0011;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            run(1, "align");
            found = m_mode == 1 && m_owner == 0 && m_t % DIV == DIV - 3 && m_s == 4'b0011;
        end
        check("align_found", 16'(found), 16'h1);
        req = 4'b0010;
        run(2, "drop_tick");
        check("drop_tick_step_en", 16'(step_en), 16'h0);
        check("drop_tick_grant0", 16'(grant), 16'h1);
        run(40, "after_drop");
        req = 4'b0100;
        run(40, "pre_rst");
        #3 rst_n = 1'b0;
        #1;
        check("rst_grant", 16'(grant), 16'h0);
        check("rst_step_en", 16'(step_en), 16'h0);
        check("rst_led", led_out, 16'h0);
        check("rst_frame_done", 16'(frame_done), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        model_reset();
        run(2, "in_rst");
        rst_n = 1'b1;
        req = 4'b1111;
        run(3, "post_rst");
        check("post_rst_grant", 16'(grant), 16'h1);
        run(60, "all4");
        repeat (60) begin
            req = 4'($urandom);
            run($urandom_range(1, 40), "random");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
